// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed RV32I data memory for the MEM stage.
// Handles LB/LH/LW/LBU/LHU and SB/SH/SW with little-endian byte lanes and
// misalignment/illegal-funct3 detection. Every accepted request yields one
// tagged response LATENCY cycles later.
module dmem_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_tag,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [31:0]           resp_rdata,
  output logic [4:0]            resp_tag,
  output logic                  resp_err,
  output logic [15:0]           err_count
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned Depth = 2 ** IdxW;

  // Array powers up to zero; clear deliberately leaves contents alone.
  logic [31:0] mem_q [Depth] = '{default: 32'h0};

  logic [IdxW-1:0] word_idx;
  logic [1:0]      lane;
  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic            req_err;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lane;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [31:0]     load_data;

  // Response pipeline; index LATENCY-1 drives the outputs.
  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY-1:0]       wr_q;
  logic [LATENCY-1:0]       err_q;
  logic [LATENCY-1:0][4:0]  tag_q;
  logic [LATENCY-1:0][31:0] rdata_q;
  logic [15:0]              err_cnt_q;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign lane     = req_addr[1:0];
  // A request seen while clear is high is dropped entirely.
  assign accept   = req_valid & ~clear;

  // Decode funct3 into legality and alignment errors.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = lane[0];
      3'b010: misaligned = |lane;
      3'b100: illegal    = req_write;
      3'b101: begin
        illegal    = req_write;
        misaligned = lane[0];
      end
      default: illegal = 1'b1;
    endcase
    req_err = illegal | misaligned;
  end

  // Byte enables and lane-aligned store data.
  always_comb begin
    byte_en = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
    wdata_lane = req_wdata << {lane, 3'b000};
  end

  // Store commit: only enabled lanes are written, others keep their value.
  always_ff @(posedge clock) begin
    if (accept && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

  // Load data selection and extension; zero for stores and errors.
  always_comb begin
    rd_word   = mem_q[word_idx];
    rd_shift  = rd_word >> {lane, 3'b000};
    load_data = 32'h0;
    case (req_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = 32'h0;
    endcase
    if (req_write || req_err || !accept) begin
      load_data = 32'h0;
    end
  end

  // Response pipeline: stage 0 captures the request, later stages shift.
  always_ff @(posedge clock) begin
    if (clear) begin
      vld_q   <= '0;
      wr_q    <= '0;
      err_q   <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q[0]   <= accept;
      wr_q[0]    <= accept & req_write;
      err_q[0]   <= accept & req_err;
      tag_q[0]   <= accept ? req_tag : 5'd0;
      rdata_q[0] <= load_data;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i]   <= vld_q[i-1];
        wr_q[i]    <= wr_q[i-1];
        err_q[i]   <= err_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  // Saturating error counter, updated at the request edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      err_cnt_q <= 16'h0;
    end else if (accept && req_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign resp_valid = vld_q[LATENCY-1];
  assign resp_write = wr_q[LATENCY-1];
  assign resp_err   = err_q[LATENCY-1];
  assign resp_tag   = tag_q[LATENCY-1];
  assign resp_rdata = rdata_q[LATENCY-1];
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (LATENCY 1, 3, 4) share one request bus.
module tb_dmem_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;

  logic        r1_valid, r1_write, r1_err;
  logic [31:0] r1_rdata;
  logic [4:0]  r1_tag;
  logic [15:0] r1_cnt;
  logic        r3_valid, r3_write, r3_err;
  logic [31:0] r3_rdata;
  logic [4:0]  r3_tag;
  logic [15:0] r3_cnt;
  logic        r4_valid, r4_write, r4_err;
  logic [31:0] r4_rdata;
  logic [4:0]  r4_tag;
  logic [15:0] r4_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_unit #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(r1_valid), .resp_write(r1_write), .resp_rdata(r1_rdata), .resp_tag(r1_tag),
    .resp_err(r1_err), .err_count(r1_cnt)
  );

  dmem_unit #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(r3_valid), .resp_write(r3_write), .resp_rdata(r3_rdata), .resp_tag(r3_tag),
    .resp_err(r3_err), .err_count(r3_cnt)
  );

  dmem_unit #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(r4_valid), .resp_write(r4_write), .resp_rdata(r4_rdata), .resp_tag(r4_tag),
    .resp_err(r4_err), .err_count(r4_cnt)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                       input logic [9:0] a, input logic [31:0] d, input logic [4:0] t);
    req_valid  = v;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_tag    = t;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 10'h0, 32'h0, 5'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           wr    f3      addr     wdata         tag    err   rdata         cnt
    vecs[0]  = '{1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 5'd1,  1'b0, 32'h00000000, 16'd0};
    vecs[1]  = '{1'b0, 3'b010, 10'h010, 32'h0,        5'd2,  1'b0, 32'hDEADBEEF, 16'd0};
    vecs[2]  = '{1'b1, 3'b010, 10'h020, 32'h11223344, 5'd3,  1'b0, 32'h00000000, 16'd0};
    vecs[3]  = '{1'b1, 3'b000, 10'h021, 32'hAAAAAA80, 5'd4,  1'b0, 32'h00000000, 16'd0};
    vecs[4]  = '{1'b0, 3'b000, 10'h021, 32'h0,        5'd5,  1'b0, 32'hFFFFFF80, 16'd0};
    vecs[5]  = '{1'b0, 3'b100, 10'h021, 32'h0,        5'd6,  1'b0, 32'h00000080, 16'd0};
    vecs[6]  = '{1'b0, 3'b010, 10'h020, 32'h0,        5'd7,  1'b0, 32'h11228044, 16'd0};
    vecs[7]  = '{1'b0, 3'b001, 10'h022, 32'h0,        5'd8,  1'b0, 32'h00001122, 16'd0};
    vecs[8]  = '{1'b0, 3'b101, 10'h020, 32'h0,        5'd9,  1'b0, 32'h00008044, 16'd0};
    vecs[9]  = '{1'b0, 3'b001, 10'h020, 32'h0,        5'd10, 1'b0, 32'hFFFF8044, 16'd0};
    vecs[10] = '{1'b0, 3'b010, 10'h022, 32'h0,        5'd11, 1'b1, 32'h00000000, 16'd1};
    vecs[11] = '{1'b1, 3'b001, 10'h023, 32'h55555555, 5'd12, 1'b1, 32'h00000000, 16'd2};
    vecs[12] = '{1'b0, 3'b011, 10'h020, 32'h0,        5'd13, 1'b1, 32'h00000000, 16'd3};
    vecs[13] = '{1'b0, 3'b010, 10'h020, 32'h0,        5'd14, 1'b0, 32'h11228044, 16'd3};
    vecs[14] = '{1'b1, 3'b001, 10'h022, 32'hCAFEBABE, 5'd15, 1'b0, 32'h00000000, 16'd3};
    vecs[15] = '{1'b0, 3'b010, 10'h020, 32'h0,        5'd16, 1'b0, 32'hBABE8044, 16'd3};
    vecs[16] = '{1'b1, 3'b100, 10'h020, 32'h99999999, 5'd17, 1'b1, 32'h00000000, 16'd4};
    vecs[17] = '{1'b0, 3'b010, 10'h020, 32'h0,        5'd18, 1'b0, 32'hBABE8044, 16'd4};

    // Reset state on all instances.
    idle();
    clear = 1'b1;
    step();
    step();
    check("rst r1_valid", {31'h0, r1_valid}, 32'h0);
    check("rst r1_rdata", r1_rdata, 32'h0);
    check("rst r1_tag", {27'h0, r1_tag}, 32'h0);
    check("rst r1_flags", {30'h0, r1_write, r1_err}, 32'h0);
    check("rst r1_cnt", {16'h0, r1_cnt}, 32'h0);
    check("rst r3_valid", {31'h0, r3_valid}, 32'h0);
    check("rst r4_valid", {31'h0, r4_valid}, 32'h0);
    check("rst r4_cnt", {16'h0, r4_cnt}, 32'h0);
    clear = 1'b0;

    // Table: back-to-back requests, each checked on the LATENCY=1 instance.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
      step();
      check($sformatf("vec%0d valid", i), {31'h0, r1_valid}, 32'h1);
      check($sformatf("vec%0d write", i), {31'h0, r1_write}, {31'h0, vecs[i].wr});
      check($sformatf("vec%0d err", i), {31'h0, r1_err}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d tag", i), {27'h0, r1_tag}, {27'h0, vecs[i].tag});
      check($sformatf("vec%0d rdata", i), r1_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d cnt", i), {16'h0, r1_cnt}, {16'h0, vecs[i].exp_cnt});
    end

    // Bubble: all response outputs zero, valid lasted one cycle.
    idle();
    step();
    check("bubble valid", {31'h0, r1_valid}, 32'h0);
    check("bubble rdata", r1_rdata, 32'h0);
    check("bubble tag", {27'h0, r1_tag}, 32'h0);

    // LATENCY=3 ordering: LW, SW 5, LW to 0x10 in consecutive cycles.
    repeat (5) step();
    for (int c = 0; c < 7; c++) begin
      logic ev;
      logic [4:0] et;
      logic [31:0] ed;
      case (c)
        0:       drive(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd7);
        1:       drive(1'b1, 1'b1, 3'b010, 10'h010, 32'h5, 5'd8);
        2:       drive(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd9);
        default: idle();
      endcase
      step();
      ev = (c >= 2) && (c <= 4);
      et = (c == 2) ? 5'd7 : (c == 3) ? 5'd8 : 5'd9;
      ed = (c == 2) ? 32'hDEADBEEF : (c == 3) ? 32'h0 : 32'h5;
      check($sformatf("lat3 c%0d valid", c), {31'h0, r3_valid}, {31'h0, ev});
      if (ev) begin
        check($sformatf("lat3 c%0d tag", c), {27'h0, r3_tag}, {27'h0, et});
        check($sformatf("lat3 c%0d rdata", c), r3_rdata, ed);
        check($sformatf("lat3 c%0d write", c), {31'h0, r3_write}, {31'h0, c == 3});
      end
    end

    // LATENCY=4 clear mid-flight; the store issued during clear is dropped.
    repeat (5) step();
    for (int c = 0; c < 10; c++) begin
      clear = (c == 3);
      case (c)
        0:       drive(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd10);
        1:       drive(1'b1, 1'b0, 3'b000, 10'h010, 32'h0, 5'd11);
        2:       drive(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd12);
        3:       drive(1'b1, 1'b1, 3'b010, 10'h030, 32'h77, 5'd20);
        default: idle();
      endcase
      step();
      check($sformatf("clr c%0d r4_valid", c), {31'h0, r4_valid}, 32'h0);
      if (c >= 3) begin
        check($sformatf("clr c%0d r4_out", c), {r4_rdata[25:0], r4_tag, r4_write},
              32'h0);
        check($sformatf("clr c%0d r4_cnt", c), {16'h0, r4_cnt}, 32'h0);
      end
    end
    clear = 1'b0;

    // First requests after clear respond normally.
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd13);
        1:       drive(1'b1, 1'b0, 3'b010, 10'h030, 32'h0, 5'd14);
        default: idle();
      endcase
      step();
      check($sformatf("post c%0d r4_valid", c), {31'h0, r4_valid}, {31'h0, c == 3 || c == 4});
      if (c == 0) check("post r1 rdata", r1_rdata, 32'h5);
      if (c == 3) begin
        check("post r4 tag13", {27'h0, r4_tag}, 32'd13);
        check("post r4 rdata13", r4_rdata, 32'h5);
      end
      if (c == 4) begin
        check("post r4 tag14", {27'h0, r4_tag}, 32'd14);
        check("post r4 rdata14", r4_rdata, 32'h0);
      end
    end

    // Saturation: 65537 errored requests.
    drive(1'b1, 1'b0, 3'b010, 10'h022, 32'h0, 5'd3);
    repeat (65534) step();
    check("sat cnt fffe", {16'h0, r1_cnt}, 32'h0000FFFE);
    repeat (3) step();
    check("sat cnt ffff", {16'h0, r1_cnt}, 32'h0000FFFF);
    check("sat err flag", {31'h0, r1_err}, 32'h1);
    idle();
    step();
    check("sat hold r1", {16'h0, r1_cnt}, 32'h0000FFFF);
    check("sat hold r4", {16'h0, r4_cnt}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
